// File: rtl/pwm_duty_scheduler.sv
// rtl/pwm_duty_scheduler.sv - shared-period PWM with round-robin duty updates committed at the period wrap
// Optional macro PWM_RAMP_EN: active duty slews toward shadow by RAMP_STEP per period.
module pwm_duty_scheduler #(
    parameter int NCH       = 4,
    parameter int NREQ      = 2,
    parameter int WIDTH     = 8,
    parameter int PERIOD    = 199,
    parameter int CW        = 2,
    parameter int RAMP_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*CW-1:0]    req_chan,
    input  logic [NREQ*WIDTH-1:0] req_duty,
    output logic [NREQ-1:0]       req_ack,
    output logic [NCH-1:0]        pwm,
    output logic                  period_tick,
    output logic [NCH-1:0]        pending
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] TERM = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] FULL = WIDTH'(PERIOD + 1);
`ifdef PWM_RAMP_EN
    localparam int STEP = RAMP_STEP;
`else
    // A step spanning the whole duty range makes every commit a full copy.
    localparam int STEP = (RAMP_STEP > (1 << WIDTH)) ? RAMP_STEP : (1 << WIDTH);
`endif

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow   [NCH];
    logic [WIDTH-1:0] active   [NCH];
    logic [WIDTH-1:0] act_next [NCH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant_idx;
    logic             grant_vld;
    logic [NREQ-1:0]  mask;
    logic [CW-1:0]    gchan;
    logic [WIDTH-1:0] graw;
    logic [WIDTH-1:0] gduty;
    logic             gwrite;
    logic             wrap;
    logic             commit;

    assign wrap   = enable && (cnt == TERM);
    assign commit = wrap || !enable;
    // A requester being acked this cycle is still showing its old request.
    assign mask   = req_valid & ~req_ack;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && mask[(int'(ptr) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign gchan  = req_chan[int'(grant_idx)*CW +: CW];
    assign graw   = req_duty[int'(grant_idx)*WIDTH +: WIDTH];
    assign gduty  = (graw > FULL) ? FULL : graw;
    assign gwrite = grant_vld && (int'(gchan) < NCH);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            act_next[c] = shadow[c];
            if (enable && (shadow[c] > active[c]) &&
                (int'(shadow[c]) - int'(active[c]) > STEP))
                act_next[c] = active[c] + WIDTH'(STEP);
            else if (enable && (active[c] > shadow[c]) &&
                     (int'(active[c]) - int'(shadow[c]) > STEP))
                act_next[c] = active[c] - WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            ptr         <= PW'(NREQ - 1);
            req_ack     <= '0;
            pwm         <= '0;
            period_tick <= 1'b0;
            pending     <= '0;
            for (int c = 0; c < NCH; c++) begin
                shadow[c] <= '0;
                active[c] <= '0;
            end
        end else begin
            cnt         <= (!enable || wrap) ? '0 : cnt + 1'b1;
            period_tick <= wrap;
            req_ack     <= '0;
            if (grant_vld) begin
                req_ack[grant_idx] <= 1'b1;
                ptr                <= grant_idx;
            end
            for (int c = 0; c < NCH; c++) begin
                pwm[c] <= enable && (cnt < active[c]);
                if (commit && pending[c]) begin
                    active[c]  <= act_next[c];
                    pending[c] <= (act_next[c] != shadow[c]);
                end
                // A write landing on a commit cycle wins pending, so it commits next period.
                if (gwrite && (gchan == CW'(c))) begin
                    shadow[c]  <= gduty;
                    pending[c] <= 1'b1;
                end
            end
        end
    end

endmodule
